// File: rtl/sram_mem_stage_pkg.sv
// Shared constants and state encoding for the memory stage.
//   WORD_WIDTH      : core datapath width
//   REG_FILE_DEPTH  : width of a register-file index
//   SRAM_DATA_WIDTH : external SRAM data bus width (one halfword)
//   mem_state_e     : SRAM controller states
package sram_mem_stage_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int REG_FILE_DEPTH  = 4;
    localparam int SRAM_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        MEM_IDLE  = 3'd0,
        MEM_RD_LO = 3'd1,
        MEM_RD_HI = 3'd2,
        MEM_WR_LO = 3'd3,
        MEM_WR_HI = 3'd4,
        MEM_DONE  = 3'd5
    } mem_state_e;

    // A timed phase is one of the four halfword-access states.
    function automatic logic is_access_phase(input mem_state_e s);
        return (s == MEM_RD_LO) || (s == MEM_RD_HI) ||
               (s == MEM_WR_LO) || (s == MEM_WR_HI);
    endfunction

endpackage

// File: rtl/sram_mem_stage_ctrl.sv
// sram_ctrl: FSM, wait counter and SRAM pin drivers. Splits one 32-bit
// word access into a low and a high halfword access on a 16-bit SRAM.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   rd_req_i, wr_req_i  load / store request (write wins if both set)
//   addr_i              byte address of the word
//   wdata_i             store data
//   rdata_o             assembled load data (valid once DONE is reached)
//   state_o             current FSM state (also used for debug)
//   sram_*              registered SRAM pins
//
// Handshake: the requester holds rd_req_i/wr_req_i, addr_i and wdata_i
// stable from the cycle it raises the request until the edge that leaves
// DONE. The controller accepts a request in IDLE and reports completion by
// being in DONE for exactly one cycle; on that edge the requester may drop
// the request or present the next one, which is picked up in IDLE.
module sram_ctrl
    import sram_mem_stage_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 2,
    parameter int DATA_BASE       = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       rd_req_i,
    input  logic                       wr_req_i,
    input  logic [WORD_WIDTH-1:0]      addr_i,
    input  logic [WORD_WIDTH-1:0]      wdata_i,
    output logic [WORD_WIDTH-1:0]      rdata_o,
    output mem_state_e                 state_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_o,
    output logic                       sram_dq_oe_o,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_i,
    output logic                       sram_we_n_o
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]      rdata_q, rdata_d;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_WIDTH-1:0] sram_dq_q, sram_dq_d;
    logic                       sram_oe_q, sram_oe_d;
    logic                       sram_we_n_q, sram_we_n_d;

    // Word index relative to the data base; the subtraction wraps, so an
    // address just below the base lands on the top word of the SRAM.
    logic [WORD_WIDTH-1:0]      offset;
    logic [SRAM_ADDR_WIDTH-2:0] word_idx;
    logic [SRAM_ADDR_WIDTH-1:0] half_lo, half_hi;
    logic                       unused_addr_bits;
    logic                       phase_last;

    assign offset           = addr_i - WORD_WIDTH'(DATA_BASE);
    assign word_idx         = offset[SRAM_ADDR_WIDTH:2];
    assign unused_addr_bits = ^{offset[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], offset[1:0]};
    assign half_lo          = {word_idx, 1'b0};
    assign half_hi          = {word_idx, 1'b1};
    assign phase_last       = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        sram_dq_d   = sram_dq_q;
        sram_oe_d   = 1'b0;
        sram_we_n_d = 1'b1;

        case (state_q)
            MEM_IDLE: begin
                if (wr_req_i)      state_d = MEM_WR_LO;
                else if (rd_req_i) state_d = MEM_RD_LO;
            end
            MEM_RD_LO: if (phase_last) begin
                rdata_d[15:0] = sram_dq_i;
                state_d       = MEM_RD_HI;
            end
            MEM_RD_HI: if (phase_last) begin
                rdata_d[31:16] = sram_dq_i;
                state_d        = MEM_DONE;
            end
            MEM_WR_LO: if (phase_last) state_d = MEM_WR_HI;
            MEM_WR_HI: if (phase_last) state_d = MEM_DONE;
            MEM_DONE:  state_d = MEM_IDLE;
            default:   state_d = MEM_IDLE;
        endcase

        // Counter restarts on every phase change and only runs inside a phase.
        if (state_d != state_q)          cnt_d = '0;
        else if (is_access_phase(state_q)) cnt_d = cnt_q + 1'b1;
        else                             cnt_d = '0;

        // Pins are registered from the next state so they line up with it.
        case (state_d)
            MEM_RD_LO: sram_addr_d = half_lo;
            MEM_RD_HI: sram_addr_d = half_hi;
            MEM_WR_LO: begin
                sram_addr_d = half_lo;
                sram_dq_d   = wdata_i[15:0];
                sram_oe_d   = 1'b1;
                sram_we_n_d = 1'b0;
            end
            MEM_WR_HI: begin
                sram_addr_d = half_hi;
                sram_dq_d   = wdata_i[31:16];
                sram_oe_d   = 1'b1;
                sram_we_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            sram_dq_q   <= '0;
            sram_oe_q   <= 1'b0;
            sram_we_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            sram_dq_q   <= sram_dq_d;
            sram_oe_q   <= sram_oe_d;
            sram_we_n_q <= sram_we_n_d;
        end
    end

    assign state_o      = state_q;
    assign rdata_o      = rdata_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_dq_o    = sram_dq_q;
    assign sram_dq_oe_o = sram_oe_q;
    assign sram_we_n_o  = sram_we_n_q;

endmodule

// File: rtl/sram_mem_stage.sv
// sram_mem_stage: memory stage of the pipelined core. Runs LDR/STR against
// a 16-bit SRAM through sram_ctrl, stalls upstream while an access is in
// flight, and holds the MEM/WB register feeding register-file write-back.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_r_en, mem_w_en            load / store request from EXE/MEM
//   wb_en_in, dest_in             write-back enable and destination
//   alu_result                    ALU result, also the byte address
//   st_value                      store data
//   ready                         1 = upstream may advance
//   wb_en, wb_dest, wb_value      registered write-back outputs
//   sram_addr, sram_dq_o, sram_dq_oe, sram_dq_i, sram_we_n   SRAM pins
module sram_mem_stage
    import sram_mem_stage_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 2,
    parameter int DATA_BASE       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_r_en,
    input  logic                       mem_w_en,
    input  logic                       wb_en_in,
    input  logic [REG_FILE_DEPTH-1:0]  dest_in,
    input  logic [WORD_WIDTH-1:0]      alu_result,
    input  logic [WORD_WIDTH-1:0]      st_value,
    output logic                       ready,
    output logic                       wb_en,
    output logic [REG_FILE_DEPTH-1:0]  wb_dest,
    output logic [WORD_WIDTH-1:0]      wb_value,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_o,
    output logic                       sram_dq_oe,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_i,
    output logic                       sram_we_n
);

    mem_state_e              ctrl_state;
    logic [WORD_WIDTH-1:0]   rdata;

    logic                      wb_en_q, wb_en_d;
    logic [REG_FILE_DEPTH-1:0] wb_dest_q, wb_dest_d;
    logic [WORD_WIDTH-1:0]     wb_value_q, wb_value_d;

    sram_ctrl #(
        .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH),
        .WAIT_CYCLES     (WAIT_CYCLES),
        .DATA_BASE       (DATA_BASE)
    ) u_ctrl (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_req_i     (mem_r_en),
        .wr_req_i     (mem_w_en),
        .addr_i       (alu_result),
        .wdata_i      (st_value),
        .rdata_o      (rdata),
        .state_o      (ctrl_state),
        .sram_addr_o  (sram_addr),
        .sram_dq_o    (sram_dq_o),
        .sram_dq_oe_o (sram_dq_oe),
        .sram_dq_i    (sram_dq_i),
        .sram_we_n_o  (sram_we_n)
    );

    // A pending request stalls even in IDLE, so the upstream latch never
    // advances past an access that has not started yet.
    assign ready = ((ctrl_state == MEM_IDLE) && !mem_r_en && !mem_w_en) ||
                   (ctrl_state == MEM_DONE);

    always_comb begin
        wb_en_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        if (ready) begin
            wb_en_d    = wb_en_in & ~mem_w_en;
            wb_dest_d  = dest_in;
            wb_value_d = mem_r_en ? rdata : alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
        end else begin
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_value = wb_value_q;

endmodule

// File: tb/tb_sram_mem_stage.sv
module tb_sram_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_result, st_value;
  logic        ready, wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i = 16'h0;
  logic        sram_we_n;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit illegal_seen = 1'b0;

  logic [15:0] sram_mem [logic [17:0]];

  sram_mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .wb_en_in   (wb_en_in),
    .dest_in    (dest_in),
    .alu_result (alu_result),
    .st_value   (st_value),
    .ready      (ready),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_we_n  (sram_we_n)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // SRAM model: pins are stable mid-cycle, so write and read on negedge.
  always @(negedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] = sram_dq_o;
    sram_dq_i <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 16'h0000;
  end

  // Protocol monitor: both requests at once is illegal upstream behaviour.
  always @(negedge clk) begin
    if (!rst && mem_r_en && mem_w_en) begin
      if (!illegal_seen) $display("protocol assertion: mem_r_en and mem_w_en both set at %0t", $time);
      illegal_seen = 1'b1;
    end
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic set_idle();
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    wb_en_in   = 1'b0;
    dest_in    = 4'd0;
    alu_result = 32'd0;
    st_value   = 32'd0;
  endtask

  // Present a memory request at posedge+1 and walk it to DONE, checking
  // pins, stall and bubble every cycle. Returns at DONE (posedge+1).
  task automatic mem_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] st, input logic [3:0] dest,
                        input logic [17:0] lo, input logic [3:0] hold_dest,
                        input logic [31:0] hold_val);
    logic [17:0] hi;
    hi = {lo[17:1], 1'b1};
    mem_r_en   = rd;
    mem_w_en   = wr;
    wb_en_in   = 1'b1;
    dest_in    = dest;
    alu_result = addr;
    st_value   = st;
    #1;
    check("req_ready_low", ready, 0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      check("stall_ready", ready, (i == 5) ? 1 : 0);
      check("bubble_wb_en", wb_en, 0);
      check("hold_wb_dest", wb_dest, hold_dest);
      check("hold_wb_value", wb_value, hold_val);
      if (i <= 4) begin
        check("sram_addr", sram_addr, (i <= 2) ? lo : hi);
        if (wr) begin
          check("wr_we_n", sram_we_n, 0);
          check("wr_oe", sram_dq_oe, 1);
          check("wr_dq_o", sram_dq_o, (i <= 2) ? st[15:0] : st[31:16]);
        end else begin
          check("rd_we_n", sram_we_n, 1);
          check("rd_oe", sram_dq_oe, 0);
        end
      end else begin
        check("done_we_n", sram_we_n, 1);
        check("done_oe", sram_dq_oe, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_dest", wb_dest, 0);
    check("rst_wb_value", wb_value, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_dq_o", sram_dq_o, 0);
    check("rst_oe", sram_dq_oe, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_ready", ready, 1);
    rst = 1'b0;

    // ALU pass-through
    wb_en_in = 1'b1; dest_in = 4'd3; alu_result = 32'h0000_00AB;
    #1 check("alu_ready", ready, 1);
    @(posedge clk); #1;
    check("alu_wb_en", wb_en, 1);
    check("alu_wb_dest", wb_dest, 3);
    check("alu_wb_value", wb_value, 32'hAB);
    set_idle();
    @(posedge clk); #1;
    check("idle_wb_en", wb_en, 0);

    // store 1032 -> halves 4/5; wb_en_in=1 must be masked
    mem_op(0, 1, 32'd1032, 32'hDEAD_BEEF, 4'd6, 18'd4, 4'd0, 32'd0);
    @(posedge clk); #1;
    check("st_wb_en", wb_en, 0);
    check("st_wb_dest", wb_dest, 6);
    check("st_wb_value", wb_value, 32'd1032);

    // load 1032 back, then ALU r2 immediately
    mem_op(1, 0, 32'd1032, 32'd0, 4'd7, 18'd4, 4'd6, 32'd1032);
    @(posedge clk); #1;
    check("ld_wb_en", wb_en, 1);
    check("ld_wb_dest", wb_dest, 7);
    check("ld_wb_value", wb_value, 32'hDEAD_BEEF);
    set_idle();
    wb_en_in = 1'b1; dest_in = 4'd2; alu_result = 32'h55;
    #1 check("b2b_ready", ready, 1);
    @(posedge clk); #1;
    check("b2b_wb_en", wb_en, 1);
    check("b2b_wb_dest", wb_dest, 2);
    check("b2b_wb_value", wb_value, 32'h55);
    set_idle();
    @(posedge clk); #1;
    check("b2b_idle_wb_en", wb_en, 0);

    // base boundary: 1024 -> halves 0/1, low address bits ignored
    mem_op(0, 1, 32'd1024, 32'h1234_5678, 4'd0, 18'd0, 4'd0, 32'd0);
    @(posedge clk); #1;
    mem_op(1, 0, 32'd1027, 32'd0, 4'd5, 18'd0, 4'd0, 32'd1024);
    @(posedge clk); #1;
    check("base_wb_en", wb_en, 1);
    check("base_wb_value", wb_value, 32'h1234_5678);

    // wrap boundary: 1020 -> halves 0x3FFFE/0x3FFFF
    mem_op(0, 1, 32'd1020, 32'hCAFE_F00D, 4'd8, 18'h3FFFE, 4'd5, 32'h1234_5678);
    @(posedge clk); #1;
    mem_op(1, 0, 32'd1020, 32'd0, 4'd9, 18'h3FFFE, 4'd8, 32'd1020);
    @(posedge clk); #1;
    check("wrap_wb_en", wb_en, 1);
    check("wrap_wb_dest", wb_dest, 9);
    check("wrap_wb_value", wb_value, 32'hCAFE_F00D);
    check("no_illegal_yet", illegal_seen, 0);

    // both requests: write path wins
    mem_op(1, 1, 32'd1032, 32'h0BAD_F00D, 4'd4, 18'd4, 4'd9, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check("both_wb_en", wb_en, 0);
    check("both_flagged", illegal_seen, 1);
    set_idle();
    @(posedge clk); #1;
    mem_op(1, 0, 32'd1032, 32'd0, 4'd1, 18'd4, 4'd0, 32'd0);
    @(posedge clk); #1;
    check("both_ld_value", wb_value, 32'h0BAD_F00D);
    check("both_ld_dest", wb_dest, 1);

    // reset in the middle of WR_HI
    mem_r_en = 1'b0; mem_w_en = 1'b1; wb_en_in = 1'b1; dest_in = 4'd11;
    alu_result = 32'd1032; st_value = 32'h1111_2222;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_addr", sram_addr, 18'd5);
    check("pre_rst_we_n", sram_we_n, 0);
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_we_n", sram_we_n, 1);
    check("mid_rst_oe", sram_dq_oe, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_ready", ready, 1);

    // pipeline runs normally after the aborted access
    wb_en_in = 1'b1; dest_in = 4'd4; alu_result = 32'h99;
    @(posedge clk); #1;
    check("post_rst_wb_en", wb_en, 1);
    check("post_rst_wb_value", wb_value, 32'h99);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
